// File: rtl/dds_multi.sv
// Multi-channel direct digital synthesiser.
// NUM_CH phase accumulators share one double-buffered configuration port. Each channel
// produces sine / triangle / sawtooth / square / trapezoid, scaled by an unsigned gain
// (0x8000 = unity) plus a signed offset with saturation.
//
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   cfg_we_i         shadow register write strobe
//   cfg_ch_i         target channel for the write
//   cfg_addr_i       0 fre, 1 pha, 2 mode, 3 duty, 4 amp, 5 offset (6,7 ignored)
//   cfg_wdata_i      write data, narrow registers take the LSBs
//   cfg_update_i     copy every shadow register set to its active set
//   cfg_sync_rst_i   with cfg_update_i, also clear every accumulator
//   wave_out_o       packed signed samples, channel c at [c*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   out_valid_o      pipeline primed
module dds_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_AW        = 2,
  parameter int unsigned PHASE_WIDTH  = 32,
  parameter int unsigned OUTPUT_WIDTH = 14
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cfg_we_i,
  input  logic [CH_AW-1:0]               cfg_ch_i,
  input  logic [2:0]                     cfg_addr_i,
  input  logic [PHASE_WIDTH-1:0]         cfg_wdata_i,
  input  logic                           cfg_update_i,
  input  logic                           cfg_sync_rst_i,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] wave_out_o,
  output logic                           out_valid_o
);

  localparam int unsigned PW = PHASE_WIDTH;

  // Sine table contents: half-wave parabola x*(512-x)/2, clamped to 32767, negated in the
  // second half. Registered per channel, so it behaves as a 1-cycle-latency ROM.
  function automatic logic [15:0] sin_rom(input logic [9:0] a);
    logic [17:0] xe;
    logic [17:0] y;
    xe = {9'd0, a[8:0]};
    y  = (xe * (18'd512 - xe)) >> 1;
    if (y > 18'd32767) y = 18'd32767;
    return a[9] ? (16'd0 - y[15:0]) : y[15:0];
  endfunction

  // Priming shift register: a one reaches bit 4 on the fifth edge after reset.
  logic [4:0] vsr_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vsr_q <= '0;
    else       vsr_q <= {vsr_q[3:0], 1'b1};
  end
  assign out_valid_o = vsr_q[4];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PW-1:0] sh_fre_q, sh_pha_q, act_fre_q, act_pha_q, acc_q, ph_q;
    logic [2:0]    sh_mode_q, act_mode_q, m1_q, m2_q, m3_q;
    logic [15:0]   sh_duty_q, sh_amp_q, sh_off_q, act_duty_q, act_amp_q, act_off_q;
    logic [15:0]   d1_q, a1_q, o1_q, a2_q, o2_q, a3_q, o3_q, a4_q, o4_q;
    logic [9:0]    addr_q;
    logic [15:0]   nraw_d, nraw2_q, raw3_q, rom_q, sel_q;
    logic [OUTPUT_WIDTH-1:0] wave_q;
    logic          wr;

    assign wr = cfg_we_i && (cfg_ch_i == CH_AW'(c));

    // Shadow / active registers. Active copies the pre-write shadow, so a write landing on
    // the update edge only takes effect at the following update.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sh_fre_q   <= '0;       sh_pha_q   <= '0;       sh_mode_q  <= '0;
        sh_duty_q  <= 16'h8000; sh_amp_q   <= 16'h8000; sh_off_q   <= '0;
        act_fre_q  <= '0;       act_pha_q  <= '0;       act_mode_q <= '0;
        act_duty_q <= 16'h8000; act_amp_q  <= 16'h8000; act_off_q  <= '0;
      end else begin
        if (cfg_update_i) begin
          act_fre_q  <= sh_fre_q;  act_pha_q <= sh_pha_q; act_mode_q <= sh_mode_q;
          act_duty_q <= sh_duty_q; act_amp_q <= sh_amp_q; act_off_q  <= sh_off_q;
        end
        if (wr) begin
          case (cfg_addr_i)
            3'd0:    sh_fre_q  <= cfg_wdata_i;
            3'd1:    sh_pha_q  <= cfg_wdata_i;
            3'd2:    sh_mode_q <= cfg_wdata_i[2:0];
            3'd3:    sh_duty_q <= cfg_wdata_i[15:0];
            3'd4:    sh_amp_q  <= cfg_wdata_i[15:0];
            3'd5:    sh_off_q  <= cfg_wdata_i[15:0];
            default: ;
          endcase
        end
      end
    end

    // Non-sine raw waveforms from the registered phase.
    logic [15:0] top16, u, v;
    assign top16 = ph_q[PW-1 -: 16];
    assign u     = ph_q[PW-2 -: 16];
    assign v     = ph_q[PW-3 -: 16];

    always_comb begin
      nraw_d = 16'h0000;
      case (m1_q)
        3'd1: nraw_d = ph_q[PW-1] ? (~u ^ 16'h8000) : (u ^ 16'h8000);
        3'd2: nraw_d = top16 ^ 16'h8000;
        3'd3: nraw_d = (top16 < d1_q) ? 16'h7FFF : 16'h8000;
        3'd4: begin
          unique case (ph_q[PW-1 -: 2])
            2'b00:   nraw_d = v ^ 16'h8000;
            2'b01:   nraw_d = 16'h7FFF;
            2'b10:   nraw_d = ~v ^ 16'h8000;
            default: nraw_d = 16'h8000;
          endcase
        end
        default: nraw_d = 16'h0000;
      endcase
    end

    // Scale: (raw * amp) >>> 15 + offset at 18 bits, saturate to 16 bits.
    logic signed [32:0] raw_x, amp_x, prod;
    logic signed [17:0] sum;
    logic [15:0]        sat;
    always_comb begin
      raw_x = {{17{sel_q[15]}}, sel_q};
      amp_x = {17'd0, a4_q};
      prod  = raw_x * amp_x;
      sum   = prod[32:15] + {{2{o4_q[15]}}, o4_q};
      if (sum > 18'sd32767)       sat = 16'h7FFF;
      else if (sum < -18'sd32768) sat = 16'h8000;
      else                        sat = sum[15:0];
    end

    // Config fields ride along with each sample through every stage.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        acc_q   <= '0; ph_q   <= '0; m1_q  <= '0; d1_q   <= '0; a1_q <= '0; o1_q <= '0;
        addr_q  <= '0; nraw2_q <= '0; m2_q <= '0; a2_q   <= '0; o2_q <= '0;
        rom_q   <= '0; raw3_q <= '0; m3_q  <= '0; a3_q   <= '0; o3_q <= '0;
        sel_q   <= '0; a4_q   <= '0; o4_q  <= '0; wave_q <= '0;
      end else begin
        acc_q   <= (cfg_update_i && cfg_sync_rst_i) ? '0 : acc_q + act_fre_q;
        ph_q    <= acc_q + act_pha_q;
        m1_q    <= act_mode_q; d1_q <= act_duty_q; a1_q <= act_amp_q; o1_q <= act_off_q;
        addr_q  <= ph_q[PW-1 -: 10];
        nraw2_q <= nraw_d;
        m2_q    <= m1_q; a2_q <= a1_q; o2_q <= o1_q;
        rom_q   <= sin_rom(addr_q);
        raw3_q  <= nraw2_q;
        m3_q    <= m2_q; a3_q <= a2_q; o3_q <= o2_q;
        sel_q   <= (m3_q == 3'd0) ? rom_q : raw3_q;
        a4_q    <= a3_q; o4_q <= o3_q;
        wave_q  <= sat[15 -: OUTPUT_WIDTH];
      end
    end

    assign wave_out_o[c*OUTPUT_WIDTH +: OUTPUT_WIDTH] = wave_q;

    logic unused_bits;
    assign unused_bits = ^{ph_q, prod, sat};
  end

endmodule
